// File: rtl/sram22_port_arbiter_pkg.sv
// rtl/sram22_port_arbiter_pkg.sv - shared types and constants for the SRAM22 port arbiter
// Purpose: requester count, default macro geometry, requester index type and a grant decode helper.
package sram22_arb_pkg;

    localparam int NUM_REQ         = 2;
    localparam int SRAM_DATA_WIDTH = 32;
    localparam int SRAM_ADDR_WIDTH = 11;

    typedef logic req_id_t;

    // Index of the set bit in a one-hot (or zero) two-way grant vector.
    function automatic req_id_t gnt_to_id(input logic [NUM_REQ-1:0] gnt);
        return gnt[1];
    endfunction

endpackage

// File: rtl/sram22_port_arbiter_if.sv
// rtl/sram22_port_arbiter_if.sv - request/response channels and macro pins of the SRAM22 port arbiter
// Purpose: bundles the two client channels and the macro control pins.
// Ports (modport slave = arbiter side):
//   in : req_valid, req_we, req_addr, req_wdata, rsp_ready, sram_dout
//   out: req_ready, rsp_valid, rsp_rdata, sram_we, sram_addr, sram_din
// Requester i uses bit i, or slice [i*W +: W] of the packed vectors.
interface sram22_port_arbiter_if
    import sram22_arb_pkg::*;
#(
    parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [NUM_REQ-1:0]            rsp_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] rsp_rdata;
    logic                          sram_we;
    logic [ADDR_WIDTH-1:0]         sram_addr;
    logic [DATA_WIDTH-1:0]         sram_din;
    logic [DATA_WIDTH-1:0]         sram_dout;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, sram_dout,
        output req_ready, rsp_valid, rsp_rdata, sram_we, sram_addr, sram_din
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, sram_dout,
        input  req_ready, rsp_valid, rsp_rdata, sram_we, sram_addr, sram_din
    );
endinterface

// File: rtl/sram22_port_arbiter_rr.sv
// rtl/sram22_port_arbiter_rr.sv - two-way round-robin grant with priority flop
// Purpose: grants the preferred eligible requester, else the other one.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   elig[1:0]       requester may be granted this cycle
//   advance         a grant was actually accepted this cycle
//   gnt[1:0]        one-hot or zero grant
module sram22_rr_arbiter
    import sram22_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] elig,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt
);

    req_id_t prio_q, prio_d;
    req_id_t alt;

    assign alt = ~prio_q;

    always_comb begin
        gnt = '0;
        if (elig[prio_q]) begin
            gnt[prio_q] = 1'b1;
        end else if (elig[alt]) begin
            gnt[alt] = 1'b1;
        end
    end

    // Preference moves to whoever did not just win.
    always_comb begin
        prio_d = prio_q;
        if (advance) begin
            prio_d = ~gnt_to_id(gnt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/sram22_port_arbiter.sv
// rtl/sram22_port_arbiter.sv - two-client arbiter and sequencer for a single-port SRAM22 macro
// Purpose: arbitrates two valid/ready request channels onto the macro, tracks the
// single read in flight and returns data through one-entry response buffers.
// Ports:
//   clk, rst   clock shared with the macro, synchronous active-high reset
//   bus        arbiter side of sram22_port_arbiter_if (client channels + macro pins)
module sram22_port_arbiter
    import sram22_arb_pkg::*;
#(
    parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH
)
(
    input  logic                   clk,
    input  logic                   rst,
    sram22_port_arbiter_if.slave   bus
);

    logic                          inflight_vld_q, inflight_vld_d;
    req_id_t                       inflight_id_q, inflight_id_d;
    logic [NUM_REQ-1:0]            rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ*DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [NUM_REQ-1:0] outstanding;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] accept;
    logic               any_gnt;
    req_id_t            gnt_id;

    // A read is blocked while one is in flight or buffered for the same client;
    // a buffer being popped this cycle has room by the time the new read returns.
    always_comb begin
        outstanding = '0;
        elig        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            outstanding[i] = (inflight_vld_q && (inflight_id_q == req_id_t'(i))) ||
                             (rsp_valid_q[i] && !bus.rsp_ready[i]);
            elig[i]        = bus.req_valid[i] && (bus.req_we[i] || !outstanding[i]);
        end
    end

    sram22_rr_arbiter u_rr (
        .clk     (clk),
        .rst     (rst),
        .elig    (elig),
        .advance (any_gnt),
        .gnt     (gnt)
    );

    assign accept        = rst ? '0 : gnt;
    assign any_gnt       = |accept;
    assign gnt_id        = gnt_to_id(accept);
    assign bus.req_ready = accept;

    // Idle cycles issue a read of address 0 whose data is never captured.
    always_comb begin
        bus.sram_we   = 1'b0;
        bus.sram_addr = '0;
        bus.sram_din  = '0;
        if (any_gnt) begin
            bus.sram_we   = bus.req_we[gnt_id];
            bus.sram_addr = bus.req_addr[int'(gnt_id)*ADDR_WIDTH +: ADDR_WIDTH];
            bus.sram_din  = bus.req_wdata[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        inflight_vld_d = any_gnt && !bus.req_we[gnt_id];
        inflight_id_d  = gnt_id;
        rsp_valid_d    = rsp_valid_q & ~bus.rsp_ready;
        rsp_rdata_d    = rsp_rdata_q;
        // Capture wins over a same-cycle pop so the new word stays valid.
        if (inflight_vld_q) begin
            rsp_valid_d[inflight_id_q] = 1'b1;
            rsp_rdata_d[int'(inflight_id_q)*DATA_WIDTH +: DATA_WIDTH] = bus.sram_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_vld_q <= 1'b0;
            inflight_id_q  <= 1'b0;
            rsp_valid_q    <= '0;
            rsp_rdata_q    <= '0;
        end else begin
            inflight_vld_q <= inflight_vld_d;
            inflight_id_q  <= inflight_id_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/sram22_port_arbiter.md
# sram22_port_arbiter

Two-requester round-robin arbiter and sequencer for a single-port SRAM22 macro (2048×32, one-cycle registered read, `we` selects write vs. read every clock). It sits directly in front of the macro, lets two clients share the one port through valid/ready request channels, and returns read data through per-requester valid/ready response channels, each with a one-entry holding buffer. The arbiter owns all macro control pins. Clients never drive the macro directly.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width; must match the macro.
- `ADDR_WIDTH`, 11: address width; must match the macro.
- `NUM_REQ`, 2: number of requesters; fixed at 2, not overridable.

Ports (requester `i` uses bit `i`, or slice `[i*W +: W]` of packed vectors):
- `clk`  in  1  single clock, shared with the macro.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  2  request present.
- `req_ready`  out  2  request accepted this cycle when `valid & ready`.
- `req_we`  in  2  1 = write, 0 = read.
- `req_addr`  in  2*ADDR_WIDTH  word address.
- `req_wdata`  in  2*DATA_WIDTH  write data.
- `rsp_valid`  out  2  read data available.
- `rsp_ready`  in  2  read data consumed when `valid & ready`.
- `rsp_rdata`  out  2*DATA_WIDTH  read data.
- `sram_we`  out  1  to macro `we`.
- `sram_addr`  out  ADDR_WIDTH  to macro `addr`.
- `sram_din`  out  DATA_WIDTH  to macro `din`.
- `sram_dout`  in  DATA_WIDTH  from macro `dout`.

## Operation
**Eligibility.** Requester `i` is eligible when `req_valid[i]` is high and one of the following holds:
- the request is a write, or
- the request is a read and requester `i` has no read outstanding. Outstanding means in flight (`inflight_vld` with `inflight_id==i`) or buffered (`rsp_valid[i]`). The exception is that a buffered response being popped this cycle (`rsp_valid[i] & rsp_ready[i]`) does not block a new read.

**Grant.** Round-robin among eligible requesters.
- `prio` (1 bit) names the preferred requester.
- After any accepted grant, `prio` becomes the other requester. With no grant, `prio` holds.
- `req_ready` is one-hot or zero, combinational from `req_valid`, `req_we`, buffer state and `prio`.

**Macro drive** (combinational):
- Grant: `sram_we = req_we[g]`, `sram_addr = req_addr[g]`, `sram_din = req_wdata[g]`.
- No grant: `sram_we = 0`, `sram_addr = 0`, `sram_din = 0`. This performs a harmless dummy read; its `dout` is ignored.

**Read tracking.**
- An accepted read sets `inflight_vld`/`inflight_id` at that clock edge.
- On the next edge, `sram_dout` is captured into `rsp_rdata[inflight_id]` and `rsp_valid[inflight_id]` is set.
- A write never produces a response. The `x` that the macro drives on `dout` after a write is never captured.

**Response buffer.** `rsp_valid[i]` clears on `rsp_valid & rsp_ready`, unless a capture for `i` happens in the same cycle, in which case it stays set with the new data. Eligibility prevents that capture from ever landing in a full buffer.

**Reset.** `rst` high forces `req_ready = 0` and `sram_we = 0` combinationally. On the edge:
- `prio`, `inflight_vld` and `rsp_valid` clear; a read in flight is dropped.
- `rsp_rdata` is zeroed.

## Timing
- Request accepted at edge k.
- Macro samples the request at edge k; data is valid on `sram_dout` during cycle k+1.
- Capture at edge k+1; `rsp_valid` is high from k+1. Read latency is 2 edges from accept to response.
- Throughput: one macro access per cycle. Each requester is limited to one read per 2 cycles when its consumer has `rsp_ready` held high, because the in-flight read blocks the next one.
- Write is committed at edge k with no response.
- Simultaneous eligible requests: requester `prio` wins, and the other sees `req_ready = 0` and must hold its request stable.
- Back-to-back grants alternate when both requesters are continuously eligible. No requester waits more than one grant.
- Reset outputs: `req_ready = 0`, `rsp_valid = 0`, `rsp_rdata = 0`, `sram_we = 0`, `sram_addr = 0`, `sram_din = 0`.

## Structure
- Package `sram22_arb_pkg`:
  - `NUM_REQ = 2`
  - `req_id_t` (1-bit requester index)
  - default `SRAM_DATA_WIDTH = 32`, `SRAM_ADDR_WIDTH = 11`
- Sub-module `sram22_rr_arbiter`: 2-way round-robin grant, with inputs `elig[1:0]` and `advance` and output one-hot `gnt`. It owns the `prio` flop and uses the same `clk`/`rst`.
- The top level holds the eligibility logic, macro mux, in-flight tracker and both response buffers.

## Test plan
- **Write then read, single requester.** Req0 writes 0xDEADBEEF @0x005, then reads @0x005 with `rsp_ready` = 1 → `rsp_valid[0]` is high exactly 2 edges after the read is accepted, with `rsp_rdata[0]` = 0xDEADBEEF. `rsp_valid[1]` never asserts.
- **Contention.** Both requesters hold reads (@0x001, @0x002; memory preloaded 0x11, 0x22) from reset → req0 is granted first, then req1 one cycle later. Responses are 0x11 and 0x22 on their own channels; `prio` alternates.
- **Backpressure.** Req1 reads @0x010 with `rsp_ready[1]` = 0 and issues a second read → the second read's `req_ready[1]` stays 0 while req0 writes are granted every cycle. Raising `rsp_ready[1]` for 1 cycle pops the data, and the second read is accepted in that same cycle.
- **Write and read collide.** Req0 writes 0xA5A5A5A5 @0x7FF while req1 reads @0x7FF in the same cycle with `prio` = 0 → the write goes first and the read returns 0xA5A5A5A5. No response is issued for the write.
- **Reset mid-read.** Assert `rst` on the cycle after a read is accepted → no `rsp_valid` ever asserts for that read. All outputs are at their reset values on the following cycle, and req0 has priority afterwards.
- **Idle.** With no `req_valid` for 10 cycles → `sram_we` = 0, `sram_addr` = 0 and `rsp_valid` = 0 throughout.
